// File: rtl/cacheline_adaptor.sv
// Cache-side line responder: turns one 256-bit pmem read/write into a burst of
// BURST_WIDTH-bit beats on the downstream memory bus, gathering or splitting the line.
module cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [31:0]            pmem_address,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic [31:0]            burst_address,
  output logic                   burst_read,
  output logic                   burst_write,
  output logic [BURST_WIDTH-1:0] burst_wdata,
  input  logic [BURST_WIDTH-1:0] burst_rdata,
  input  logic                   burst_resp
);

  localparam int unsigned Beats = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;
  logic [LINE_WIDTH-1:0]   wline_q, wline_d;
  logic                    burst_read_q, burst_read_d;
  logic                    burst_write_q, burst_write_d;

  // Line offset bits are dropped from the burst address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[4:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rline_d = rline_q;
    wline_d = wline_q;
    unique case (state_q)
      StIdle: begin
        // Write wins if both requests are (illegally) high.
        if (pmem_write) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          wline_d = pmem_wdata;
          cnt_d   = '0;
          state_d = StWrite;
        end else if (pmem_read) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (burst_resp) begin
          rline_d[32'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] = burst_rdata;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        if (burst_resp) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Burst requests are flopped from the next state so they line up with it.
    burst_read_d  = (state_d == StRead);
    burst_write_d = (state_d == StWrite);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      rline_q       <= '0;
      wline_q       <= '0;
      burst_read_q  <= 1'b0;
      burst_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      rline_q       <= rline_d;
      wline_q       <= wline_d;
      burst_read_q  <= burst_read_d;
      burst_write_q <= burst_write_d;
    end
  end

  assign pmem_rdata    = rline_q;
  assign pmem_resp     = (state_q == StResp);
  assign burst_address = addr_q;
  assign burst_read    = burst_read_q;
  assign burst_write   = burst_write_q;
  assign burst_wdata   = wline_q[32'(cnt_q) * BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes with waits, write priority,
// mid-burst reset, back-to-back transactions and spurious burst_resp.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] L1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] L2 = {64'hdead_beef_0000_0004, 64'hdead_beef_0000_0003,
                                 64'hdead_beef_0000_0002, 64'hdead_beef_0000_0001};
  localparam logic [255:0] L3 = {64'h0a0a_0a0a_0a0a_0a0a, 64'h5050_5050_5050_5050,
                                 64'hc3c3_c3c3_c3c3_c3c3, 64'h1f2e_3d4c_5b6a_7988};
  localparam logic [255:0] W1 = {64'hfedc_ba98_7654_3210, 64'h0f1e_2d3c_4b5a_6978,
                                 64'h89ab_cdef_0123_4567, 64'h0123_4567_89ab_cdef};
  localparam logic [255:0] W2 = {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000,
                                 64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000};

  cacheline_adaptor #(
    .LINE_WIDTH (256),
    .BURST_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_address(burst_address),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int waits,
                         input logic [255:0] prev);
    int cyc;
    pmem_address = addr;
    pmem_read    = 1'b1;
    step();
    cyc = 1;
    check_eq("rd_addr", burst_address, {addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < waits; w++) begin
        check_eq("rd_wait_req", {burst_write, burst_read}, 2'b01);
        check_eq("rd_wait_noresp", pmem_resp, 1'b0);
        step();
        cyc++;
      end
      check_eq("rd_req", {burst_write, burst_read}, 2'b01);
      check_eq("rd_noresp", pmem_resp, 1'b0);
      if (b == 0) check_eq("rd_hold_prev", pmem_rdata, prev);
      burst_rdata = line[b*64 +: 64];
      burst_resp  = 1'b1;
      step();
      cyc++;
      burst_resp  = 1'b0;
      burst_rdata = '0;
    end
    check_eq("rd_resp", pmem_resp, 1'b1);
    check_eq("rd_latency", cyc, 5 + 4 * waits);
    check_eq("rd_line", pmem_rdata, line);
    check_eq("rd_req_off", {burst_write, burst_read}, 2'b00);
    pmem_read = 1'b0;
    step();
    check_eq("rd_resp_once", pmem_resp, 1'b0);
    check_eq("rd_idle_req", {burst_write, burst_read}, 2'b00);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int waits,
                          input logic both, input logic [255:0] keep);
    int cyc;
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_write   = 1'b1;
    pmem_read    = both;
    step();
    cyc = 1;
    pmem_wdata = ~line;
    check_eq("wr_addr", burst_address, {addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < waits; w++) begin
        check_eq("wr_wait_req", {burst_write, burst_read}, 2'b10);
        check_eq("wr_wait_data", burst_wdata, line[b*64 +: 64]);
        check_eq("wr_wait_noresp", pmem_resp, 1'b0);
        step();
        cyc++;
      end
      check_eq("wr_req", {burst_write, burst_read}, 2'b10);
      check_eq("wr_data", burst_wdata, line[b*64 +: 64]);
      check_eq("wr_noresp", pmem_resp, 1'b0);
      burst_resp = 1'b1;
      step();
      cyc++;
      burst_resp = 1'b0;
    end
    check_eq("wr_resp", pmem_resp, 1'b1);
    check_eq("wr_latency", cyc, 5 + 4 * waits);
    check_eq("wr_req_off", {burst_write, burst_read}, 2'b00);
    check_eq("wr_rdata_kept", pmem_rdata, keep);
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
    step();
    check_eq("wr_resp_once", pmem_resp, 1'b0);
    check_eq("wr_idle_req", {burst_write, burst_read}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    check_eq("rst_rdata", pmem_rdata, '0);
    check_eq("rst_resp", pmem_resp, 1'b0);
    check_eq("rst_addr", burst_address, 32'h0);
    check_eq("rst_req", {burst_write, burst_read}, 2'b00);
    check_eq("rst_wdata", burst_wdata, 64'h0);
    rst = 1'b0;
    step();
    check_eq("post_rst_resp", pmem_resp, 1'b0);

    // Zero-wait read
    do_read(32'h1234_5678, L1, 0, '0);
    check_eq("rd1_addr_held", burst_address, 32'h1234_5660);

    // Write with two wait cycles per beat, then a back-to-back read
    do_write(32'h0000_a05f, W1, 2, 1'b0, L1);
    do_read(32'hffff_ffe1, L2, 0, L1);

    // Both requests high: write wins, read line untouched
    do_write(32'h8000_0040, W2, 0, 1'b1, L2);

    // Spurious burst_resp in IDLE
    burst_resp  = 1'b1;
    burst_rdata = 64'hffff_ffff_ffff_ffff;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle_resp", pmem_resp, 1'b0);
      check_eq("idle_req", {burst_write, burst_read}, 2'b00);
      check_eq("idle_rdata", pmem_rdata, L2);
      check_eq("idle_addr", burst_address, 32'h8000_0040);
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;

    // Reset after two read beats
    pmem_address = 32'h0000_1000;
    pmem_read    = 1'b1;
    step();
    for (int b = 0; b < 2; b++) begin
      burst_rdata = L1[b*64 +: 64];
      burst_resp  = 1'b1;
      step();
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {burst_write, burst_read}, 2'b00);
    check_eq("mid_rst_resp", pmem_resp, 1'b0);
    check_eq("mid_rst_rdata", pmem_rdata, '0);
    check_eq("mid_rst_addr", burst_address, 32'h0);
    #1;
    rst       = 1'b0;
    pmem_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("after_rst_resp", pmem_resp, 1'b0);
      check_eq("after_rst_req", {burst_write, burst_read}, 2'b00);
    end
    do_read(32'h0000_1000, L3, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
